// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants and state encodings for the handshaked IF/ID pipeline stage.
// State is encoded as {skid_v, main_v}, so the valid flags fall straight out of the state bits.
package pipe_stage_hs_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_DATA_BUS = 32;

    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'b00,
        STAGE_BUSY  = 2'b01,
        STAGE_FULL  = 2'b11
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_hs_stage_slot.sv
// Width-generic holding register with load enable and asynchronous active-low reset.
// The top uses it for the main entry and, when the skid buffer is enabled, for the skid entry.
module stage_slot
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// IF/ID pipeline stage carrying {pc, inst} over a valid/ready handshake, with an optional
// two-entry skid buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_BUS,
    parameter int unsigned DATA_W = INST_DATA_BUS,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned W = ADDR_W + DATA_W;

    stage_state_e state_q;
    stage_state_e state_d;
    logic         main_v;
    logic         skid_v;
    logic         accept;
    logic         send;
    logic         main_load;
    logic         main_from_skid;
    logic         skid_load;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign {skid_v, main_v} = state_q;

    // With the skid buffer, in_ready is a pure register output; without it, it looks through to out_ready.
    assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
    assign out_valid = main_v;
    assign accept    = in_valid && in_ready;
    assign send      = main_v && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= STAGE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = STAGE_EMPTY;
        end else begin
            case (state_q)
                STAGE_EMPTY: if (accept) state_d = STAGE_BUSY;
                STAGE_BUSY: begin
                    if (accept && !send) begin
                        state_d = (SKID != 0) ? STAGE_FULL : STAGE_BUSY;
                    end else if (!accept && send) begin
                        state_d = STAGE_EMPTY;
                    end
                end
                STAGE_FULL: if (send) state_d = STAGE_BUSY;
                default:    state_d = STAGE_EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (!flush) begin
            case (state_q)
                STAGE_EMPTY: main_load = accept;
                STAGE_BUSY: begin
                    main_load = accept && send;
                    skid_load = accept && !send && (SKID != 0);
                end
                STAGE_FULL: begin
                    main_load      = send;
                    main_from_skid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : {in_pc, in_inst};

    stage_slot #(.W(W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            stage_slot #(.W(W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (skid_load),
                .d    ({in_pc, in_inst}),
                .q    (skid_q)
            );
        end else begin : g_noskid
            logic unused_skid_load;
            assign unused_skid_load = skid_load;
            assign skid_q           = '0;
        end
    endgenerate

    assign {out_pc, out_inst} = main_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
